// File: rtl/cva6_cfg_reporter_pkg.sv
// Shared definitions for the build-configuration reporter: word map, FSM
// encoding, parameter bundle and the constant word/checksum function.
package cva6_cfg_reporter_pkg;

  localparam int unsigned NUM_WORDS = 18;
  localparam logic [31:0] MAGIC     = 32'h4356_4136;

  localparam logic [4:0] W_MAGIC     = 5'd0;
  localparam logic [4:0] W_XLEN      = 5'd1;
  localparam logic [4:0] W_FEAT      = 5'd2;
  localparam logic [4:0] W_USER      = 5'd3;
  localparam logic [4:0] W_IC_ASSOC  = 5'd4;
  localparam logic [4:0] W_IC_LINES  = 5'd5;
  localparam logic [4:0] W_IC_LINE_W = 5'd6;
  localparam logic [4:0] W_DC_ASSOC  = 5'd7;
  localparam logic [4:0] W_DC_LINES  = 5'd8;
  localparam logic [4:0] W_DC_LINE_W = 5'd9;
  localparam logic [4:0] W_COMMIT    = 5'd10;
  localparam logic [4:0] W_PIPE      = 5'd11;
  localparam logic [4:0] W_TLB       = 5'd12;
  localparam logic [4:0] W_RAS       = 5'd13;
  localparam logic [4:0] W_BTB       = 5'd14;
  localparam logic [4:0] W_BHT       = 5'd15;
  localparam logic [4:0] W_PMP       = 5'd16;
  localparam logic [4:0] W_CSUM      = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_DUMP   = 2'd2
  } state_t;

  typedef struct packed {
    int unsigned xlen;
    int unsigned fpu_en;
    int unsigned f16_en;
    int unsigned f16alt_en;
    int unsigned f8_en;
    int unsigned fvec_en;
    int unsigned cvxif_en;
    int unsigned c_en;
    int unsigned a_en;
    int unsigned h_en;
    int unsigned fetch_user_en;
    int unsigned data_user_en;
    int unsigned rename_en;
    int unsigned fpga_en;
    int unsigned fetch_user_w;
    int unsigned data_user_w;
    int unsigned ic_assoc;
    int unsigned ic_lines;
    int unsigned ic_line_w;
    int unsigned dc_assoc;
    int unsigned dc_lines;
    int unsigned dc_line_w;
    int unsigned nr_commit;
    int unsigned nr_sb;
    int unsigned load_pipe;
    int unsigned store_pipe;
    int unsigned itlb;
    int unsigned dtlb;
    int unsigned ras;
    int unsigned btb;
    int unsigned bht;
    int unsigned pmp;
  } cfg_params_t;

  // Words 0..16 straight from the parameter fields; anything else reads 0.
  function automatic logic [31:0] raw_word(input logic [4:0] idx, input cfg_params_t p);
    logic [31:0] w;
    w = '0;
    case (idx)
      W_MAGIC:     w = MAGIC;
      W_XLEN:      w = p.xlen;
      W_FEAT:      w = {19'd0, p.fpga_en[0], p.rename_en[0], p.data_user_en[0],
                        p.fetch_user_en[0], p.h_en[0], p.a_en[0], p.c_en[0],
                        p.cvxif_en[0], p.fvec_en[0], p.f8_en[0], p.f16alt_en[0],
                        p.f16_en[0], p.fpu_en[0]};
      W_USER:      w = {p.data_user_w[15:0], p.fetch_user_w[15:0]};
      W_IC_ASSOC:  w = p.ic_assoc;
      W_IC_LINES:  w = p.ic_lines;
      W_IC_LINE_W: w = p.ic_line_w;
      W_DC_ASSOC:  w = p.dc_assoc;
      W_DC_LINES:  w = p.dc_lines;
      W_DC_LINE_W: w = p.dc_line_w;
      W_COMMIT:    w = {p.nr_sb[15:0], p.nr_commit[15:0]};
      W_PIPE:      w = {16'd0, p.store_pipe[7:0], p.load_pipe[7:0]};
      W_TLB:       w = {p.dtlb[15:0], p.itlb[15:0]};
      W_RAS:       w = p.ras;
      W_BTB:       w = p.btb;
      W_BHT:       w = p.bht;
      W_PMP:       w = p.pmp;
      default:     w = '0;
    endcase
    return w;
  endfunction

  // Full word map including the trailing XOR checksum over words 0..16.
  function automatic logic [31:0] cfg_word(input logic [4:0] idx, input cfg_params_t p);
    logic [31:0] csum;
    csum = '0;
    if (idx == W_CSUM) begin
      for (int i = 0; i < int'(W_CSUM); i++) begin
        csum = csum ^ raw_word(5'(i), p);
      end
      return csum;
    end
    return raw_word(idx, p);
  endfunction

endpackage

// File: rtl/cva6_cfg_reporter.sv
// Read-only responder serving the core's elaborated build parameters one
// word at a time or as an 18-word dump ending in an XOR checksum.
module cva6_cfg_reporter
  import cva6_cfg_reporter_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned FPU_EN        = 0,
  parameter int unsigned F16_EN        = 0,
  parameter int unsigned F16ALT_EN     = 0,
  parameter int unsigned F8_EN         = 0,
  parameter int unsigned FVEC_EN       = 0,
  parameter int unsigned CVXIF_EN      = 0,
  parameter int unsigned C_EN          = 1,
  parameter int unsigned A_EN          = 1,
  parameter int unsigned H_EN          = 0,
  parameter int unsigned FETCH_USER_EN = 0,
  parameter int unsigned DATA_USER_EN  = 0,
  parameter int unsigned FETCH_USER_W  = 32,
  parameter int unsigned DATA_USER_W   = 32,
  parameter int unsigned RENAME_EN     = 0,
  parameter int unsigned FPGA_EN       = 0,
  parameter int unsigned IC_ASSOC      = 4,
  parameter int unsigned IC_LINES      = 4096,
  parameter int unsigned IC_LINE_W     = 128,
  parameter int unsigned DC_ASSOC      = 8,
  parameter int unsigned DC_LINES      = 4096,
  parameter int unsigned DC_LINE_W     = 128,
  parameter int unsigned NR_COMMIT     = 2,
  parameter int unsigned NR_SB         = 8,
  parameter int unsigned LOAD_PIPE     = 1,
  parameter int unsigned STORE_PIPE    = 0,
  parameter int unsigned ITLB          = 16,
  parameter int unsigned DTLB          = 16,
  parameter int unsigned RAS           = 2,
  parameter int unsigned BTB           = 32,
  parameter int unsigned BHT           = 128,
  parameter int unsigned PMP           = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_addr_i,
  input  logic        req_dump_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        rsp_last_o,
  output state_t      dbg_state_o
);

  // Handshake: a request transfers on a cycle with req_valid_i && req_ready_o,
  // a response word transfers on rsp_valid_o && rsp_ready_i. Neither side may
  // retract valid or change its payload until the transfer happens.

  localparam cfg_params_t P = '{
    xlen: XLEN, fpu_en: FPU_EN, f16_en: F16_EN, f16alt_en: F16ALT_EN,
    f8_en: F8_EN, fvec_en: FVEC_EN, cvxif_en: CVXIF_EN, c_en: C_EN,
    a_en: A_EN, h_en: H_EN, fetch_user_en: FETCH_USER_EN,
    data_user_en: DATA_USER_EN, rename_en: RENAME_EN, fpga_en: FPGA_EN,
    fetch_user_w: FETCH_USER_W, data_user_w: DATA_USER_W,
    ic_assoc: IC_ASSOC, ic_lines: IC_LINES, ic_line_w: IC_LINE_W,
    dc_assoc: DC_ASSOC, dc_lines: DC_LINES, dc_line_w: DC_LINE_W,
    nr_commit: NR_COMMIT, nr_sb: NR_SB, load_pipe: LOAD_PIPE,
    store_pipe: STORE_PIPE, itlb: ITLB, dtlb: DTLB, ras: RAS, btb: BTB,
    bht: BHT, pmp: PMP
  };

  // Any parameter wider than its field would be silently truncated in the map.
  if (FPU_EN > 1 || F16_EN > 1 || F16ALT_EN > 1 || F8_EN > 1 || FVEC_EN > 1 ||
      CVXIF_EN > 1 || C_EN > 1 || A_EN > 1 || H_EN > 1 || FETCH_USER_EN > 1 ||
      DATA_USER_EN > 1 || RENAME_EN > 1 || FPGA_EN > 1 ||
      FETCH_USER_W > 16'hFFFF || DATA_USER_W > 16'hFFFF ||
      NR_COMMIT > 16'hFFFF || NR_SB > 16'hFFFF ||
      LOAD_PIPE > 8'hFF || STORE_PIPE > 8'hFF ||
      ITLB > 16'hFFFF || DTLB > 16'hFFFF) begin : g_param_overflow
    $error("cva6_cfg_reporter: a parameter overflows its configuration field");
  end

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic [4:0]  cnt_inc;

  assign cnt_inc = cnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          valid_d = 1'b1;
          if (req_dump_i) begin
            state_d = ST_DUMP;
            cnt_d   = '0;
            data_d  = cfg_word(W_MAGIC, P);
            err_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_SINGLE;
            last_d  = 1'b1;
            if (req_addr_i >= 5'(NUM_WORDS)) begin
              data_d = '0;
              err_d  = 1'b1;
            end else begin
              data_d = cfg_word(req_addr_i, P);
              err_d  = 1'b0;
            end
          end
        end
      end
      ST_SINGLE: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_DUMP: begin
        if (rsp_ready_i) begin
          if (cnt_q == W_CSUM) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_inc;
            data_d = cfg_word(cnt_inc, P);
            last_d = (cnt_inc == W_CSUM);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign rsp_last_o  = last_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cva6_cfg_reporter.sv
// Bench for cva6_cfg_reporter: directed vector table, multi-cycle corner
// sequences and random reads against a word-map model built from the defaults.
module tb_cva6_cfg_reporter;
  import cva6_cfg_reporter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_dump, rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [4:0]  req_addr;
  logic [31:0] rsp_data;
  state_t      dbg_state;

  cva6_cfg_reporter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_dump_i  (req_dump),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_w [18];
  logic [33:0] exp_q [$];   // {err, last, data}

  task automatic build_model();
    int fpu = 0, f16 = 0, f16alt = 0, f8 = 0, fvec = 0, cvxif = 0, c = 1, a = 1, h = 0;
    int fu = 0, du = 0, ren = 0, fpga = 0;
    model_w[0]  = 32'h43564136;
    model_w[1]  = 32;
    model_w[2]  = fpu + 2*f16 + 4*f16alt + 8*f8 + 16*fvec + 32*cvxif + 64*c + 128*a
                + 256*h + 512*fu + 1024*du + 2048*ren + 4096*fpga;
    model_w[3]  = 32 + 32 * 65536;
    model_w[4]  = 4;
    model_w[5]  = 4096;
    model_w[6]  = 128;
    model_w[7]  = 8;
    model_w[8]  = 4096;
    model_w[9]  = 128;
    model_w[10] = 2 + 8 * 65536;
    model_w[11] = 1 + 0 * 256;
    model_w[12] = 16 + 16 * 65536;
    model_w[13] = 2;
    model_w[14] = 32;
    model_w[15] = 128;
    model_w[16] = 8;
    model_w[17] = 0;
    for (int i = 0; i < 17; i++) model_w[17] = model_w[17] ^ model_w[i];
  endtask

  task automatic push_expected(input int addr, input bit dump);
    if (dump) begin
      for (int i = 0; i < 18; i++) exp_q.push_back({1'b0, (i == 17), model_w[i]});
    end else if (addr < 18) begin
      exp_q.push_back({1'b0, 1'b1, model_w[addr]});
    end else begin
      exp_q.push_back({1'b1, 1'b1, 32'd0});
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance, valid dropped.
  task automatic send_req(input int addr, input bit dump);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = 5'(addr);
    req_dump  = dump;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("req_accept_timeout");
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid_next_cycle", 32'(rsp_valid), 32'd1);
  endtask

  // ready_mode: 0 always high, 1 toggle, 2 random. Consumes responses
  // until the last word, or max_pops words if max_pops > 0.
  task automatic collect(input int ready_mode, input int max_pops, input bit inj, input bit tput);
    int cyc = 0, pops = 0;
    bit done = 0, stalled = 0;
    logic [31:0] held = '0;
    logic [33:0] e;
    while (!done) begin
      if (cyc >= 300) begin
        fail_now("collect_timeout");
        break;
      end
      if (inj && pops == 5 && !req_valid) begin
        req_valid = 1'b1;
        req_dump  = 1'b0;
        req_addr  = 5'd1;
      end
      if (stalled) begin
        check("stall_valid_held", 32'(rsp_valid), 32'd1);
        check("stall_data_held", rsp_data, held);
      end
      if (rsp_valid) begin
        check("busy_req_ready", 32'(req_ready), 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_response");
          done = 1;
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e[31:0]);
          check("rsp_last", 32'(rsp_last), 32'(e[32]));
          check("rsp_err", 32'(rsp_err), 32'(e[33]));
          case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = cyc[0];
            default: rsp_ready = ($urandom_range(0, 99) < 60);
          endcase
          stalled = !rsp_ready;
          held    = rsp_data;
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            pops++;
            if (e[32] || pops == max_pops) begin
              done = 1;
              if (tput && e[32]) check("dump_cycles", 32'(cyc + 1), 32'd18);
            end
          end
        end
      end else begin
        stalled   = 0;
        rsp_ready = $urandom_range(0, 1);
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_data"}, rsp_data, 32'd0);
    check({name, "_err"}, 32'(rsp_err), 32'd0);
    check({name, "_last"}, 32'(rsp_last), 32'd0);
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{addr: 0,  data: 32'h43564136, err: 1'b0};
    vecs[1] = '{addr: 2,  data: 32'h000000C0, err: 1'b0};
    vecs[2] = '{addr: 10, data: 32'h00080002, err: 1'b0};
    vecs[3] = '{addr: 12, data: 32'h00100010, err: 1'b0};
    vecs[4] = '{addr: 20, data: 32'h00000000, err: 1'b1};
    vecs[5] = '{addr: 4,  data: 32'h00000004, err: 1'b0};
    vecs[6] = '{addr: 31, data: 32'h00000000, err: 1'b1};

    build_model();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_dump  = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_reset_values("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_released");

    // single reads from the table, response held one stalled cycle first
    for (int i = 0; i < 7; i++) begin
      send_req(vecs[i].addr, 1'b0);
      check("tbl_data", rsp_data, vecs[i].data);
      check("tbl_err", 32'(rsp_err), 32'(vecs[i].err));
      check("tbl_last", 32'(rsp_last), 32'd1);
      check("tbl_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("tbl_stall_data", rsp_data, vecs[i].data);
      check("tbl_stall_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_idle("tbl_after");
    end

    // full dump at full rate, fixed-value spot checks on the model
    check("model_w4", model_w[4], 32'd4);
    check("model_w16", model_w[16], 32'd8);
    push_expected(0, 1'b1);
    send_req(0, 1'b1);
    collect(0, 0, 1'b0, 1'b1);
    check_idle("dump_after");

    // dump with rsp_ready toggling, plus a single request raised mid-dump
    push_expected(0, 1'b1);
    send_req(0, 1'b1);
    collect(1, 0, 1'b1, 1'b0);
    check("held_req_still_valid", 32'(req_valid), 32'd1);
    push_expected(1, 1'b0);
    send_req(1, 1'b0);
    collect(0, 0, 1'b0, 1'b0);
    check_idle("held_req_after");

    // reset asserted while dump word 9 is on the bus
    push_expected(0, 1'b1);
    send_req(0, 1'b1);
    collect(0, 9, 1'b0, 1'b0);
    check("pre_reset_word9", rsp_data, model_w[9]);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_expected(0, 1'b1);
    send_req(0, 1'b1);
    check("post_reset_word0", rsp_data, 32'h43564136);
    collect(0, 0, 1'b0, 1'b1);
    check_idle("post_reset_after");

    // random singles and dumps with random back-pressure
    for (int i = 0; i < 30; i++) begin
      int  a;
      bit  d;
      a = $urandom_range(0, 31);
      d = ($urandom_range(0, 3) == 0);
      push_expected(a, d);
      send_req(a, d);
      collect(2, 0, 1'b0, 1'b0);
      check_idle("rand_after");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cva6_cfg_reporter.md
# cva6_cfg_reporter

Read-only configuration responder that exposes the core's elaborated build parameters (XLEN, extensions, cache/TLB/predictor geometry, PMP count) to software and debug tooling over a valid/ready request/response port. It sits beside the CSR file or debug module as the reader side of the static configuration: the parameters are fixed at elaboration, and this block serves them one word at a time or as a burst dump.

## Interface
Parameters (defaults match the sv32 IMAC build):
- XLEN, 32, architectural register width
- FPU_EN, F16_EN, F16ALT_EN, F8_EN, FVEC_EN, 0, FP feature enables
- CVXIF_EN, 0 / C_EN, 1 / A_EN, 1 / H_EN, 0, extension enables
- FETCH_USER_EN, DATA_USER_EN, 0, user-signal enables; FETCH_USER_W, DATA_USER_W, 32
- RENAME_EN, 0 / FPGA_EN, 0
- IC_ASSOC, 4 / IC_LINES, 4096 / IC_LINE_W, 128
- DC_ASSOC, 8 / DC_LINES, 4096 / DC_LINE_W, 128
- NR_COMMIT, 2 / NR_SB, 8 / LOAD_PIPE, 1 / STORE_PIPE, 0
- ITLB, 16 / DTLB, 16 / RAS, 2 / BTB, 32 / BHT, 128 / PMP, 8

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with valid
- req_addr_i  in  5  word index (single mode)
- req_dump_i  in  1  1 = dump all words, ignore addr
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  response word
- rsp_err_o  out  1  index out of range
- rsp_last_o  out  1  final word of the transaction

## Operation
Word map (NUM_WORDS = 18):
- 0 magic 0x43564136; 1 XLEN
- 2 feature bitmap: b0 FPU, b1 F16, b2 F16ALT, b3 F8, b4 FVEC, b5 CVXIF, b6 C, b7 A, b8 H, b9 FETCH_USER, b10 DATA_USER, b11 RENAME, b12 FPGA; rest 0
- 3 FETCH_USER_W[15:0], DATA_USER_W[31:16]
- 4..6 IC assoc/lines/line width; 7..9 DC assoc/lines/line width
- 10 NR_COMMIT[15:0], NR_SB[31:16]; 11 LOAD_PIPE[7:0], STORE_PIPE[15:8]
- 12 ITLB[15:0], DTLB[31:16]; 13 RAS; 14 BTB; 15 BHT; 16 PMP
- 17 checksum = XOR of words 0..16
- Fields are zero-extended; elaboration assertion fails if any parameter overflows its field.

FSM states IDLE, SINGLE, DUMP:
- IDLE: req_ready_o=1. On req_valid_i: dump=0 -> SINGLE, data=word[addr], last=1, err=(addr>=18, data=0 then); dump=1 -> DUMP, counter=0, data=word 0, last=0.
- SINGLE: rsp_valid_o=1; on rsp_ready_i -> IDLE.
- DUMP: rsp_valid_o=1; on rsp_ready_i with counter<17: counter+1, load next word; on rsp_ready_i with counter=17 (last=1) -> IDLE.
- req_ready_o=0 outside IDLE; requests there are not accepted and must be held by the initiator.
- err only possible in SINGLE; dump never sets err.

## Timing
- Reset: FSM IDLE, counter 0, rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0, rsp_last_o 0, req_ready_o 1.
- All response outputs are registered. Response is valid the cycle after request acceptance.
- Response fields are stable while rsp_valid_o=1 and rsp_ready_i=0.
- Dump throughput: one word per cycle with rsp_ready_i held high. An 18-word dump completes 18 cycles after acceptance.
- After the last handshake, rsp_valid_o drops the next cycle and req_ready_o rises the same cycle (no back-to-back acceptance in the handshake cycle).
- An asserted rst_ni mid-transaction aborts immediately to the reset values. No partial response is retained.

## Structure
- Package cva6_cfg_reporter_pkg contains:
  - word index localparams, MAGIC, NUM_WORDS, state enum
  - pure function cfg_word(idx, params-struct)
  - a cfg_params_t struct carrying all parameters
- No sub-module. ROM and checksum are constant-folded combinational logic inside the block.

## Test plan
- Reset, then single read addr 0 -> next cycle rsp_valid=1, data 0x43564136, last=1, err=0, req_ready=0.
- Single read addr 2 -> 0x000000C0. Addr 10 -> 0x00080002. Addr 12 -> 0x00100010.
- Single read addr 20 -> data 0, err=1, last=1.
- Dump with rsp_ready tied high -> 18 consecutive words. Word 4 = 4, word 16 = 8, word 17 = XOR of the previous 17 words. last=1 only on word 17. req_ready=1 the cycle after.
- Dump with rsp_ready toggled 1/0 -> words do not repeat or skip, and data is held while stalled. A request issued mid-dump is not accepted until IDLE.
- rst_ni pulsed low during dump word 9 -> outputs reset asynchronously. A new dump after reset starts at word 0.
